id_ex_pipeline_reg: RTL and testbench

//  Decode-to-execute pipeline register. Captures decode-stage control bundle
//  (RegWrite/ResultSrc/MemWrite/Jump/Branch/ALUControl/ALUSrc), register-file

---
 rtl/id_ex_pipeline_reg.sv | 120 ++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register with stall (hold), flush (bubble) and a
// valid bit. Every output is driven straight from a flop.
module id_ex_pipeline_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic [2:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic [2:0]            Funct3D,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  output logic                  ValidE,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [2:0]            ALUControlE,
  output logic                  ALUSrcE,
  output logic [2:0]            Funct3E,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [2:0]            alu_control;
    logic                  alu_src;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    // NOTE: hold is the default so every path assigns stage_d and no latch is inferred.
    stage_d = stage_q;
    if (FlushE) begin
      stage_d = '0;
    end else if (!StallE) begin
      stage_d.valid       = ValidD;
      stage_d.result_src  = ResultSrcD;
      stage_d.alu_control = ALUControlD;
      stage_d.alu_src     = ALUSrcD;
      stage_d.funct3      = Funct3D;
      stage_d.rd1         = RD1D;
      stage_d.rd2         = RD2D;
      stage_d.imm_ext     = ImmExtD;
      stage_d.pc          = PCD;
      stage_d.pc_plus4    = PCPlus4D;
      stage_d.rs1         = Rs1D;
      stage_d.rs2         = Rs2D;
      stage_d.rd          = RdD;
      // A bubble keeps its data but must never commit a side effect.
      stage_d.reg_write   = RegWriteD & ValidD;
      stage_d.mem_write   = MemWriteD & ValidD;
      stage_d.jump        = JumpD     & ValidD;
      stage_d.branch      = BranchD   & ValidD;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking keeps every flop sampling pre-edge values.
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign ValidE      = stage_q.valid;
  assign RegWriteE   = stage_q.reg_write;
  assign ResultSrcE  = stage_q.result_src;
  assign MemWriteE   = stage_q.mem_write;
  assign JumpE       = stage_q.jump;
  assign BranchE     = stage_q.branch;
  assign ALUControlE = stage_q.alu_control;
  assign ALUSrcE     = stage_q.alu_src;
  assign Funct3E     = stage_q.funct3;
  assign RD1E        = stage_q.rd1;
  assign RD2E        = stage_q.rd2;
  assign ImmExtE     = stage_q.imm_ext;
  assign PCE         = stage_q.pc;
  assign PCPlus4E    = stage_q.pc_plus4;
  assign Rs1E        = stage_q.rs1;
  assign Rs2E        = stage_q.rs2;
  assign RdE         = stage_q.rd;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios followed by
// randomized traffic against a per-edge reference model.
module tb_id_ex_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst, StallE, FlushE, ValidD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD, Funct3D;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int tests_run = 0;
  int errors    = 0;

  // Expected E-stage contents, one entry per output in port order.
  logic [31:0] exp_q [17];

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .Funct3E(Funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference rule per edge: reset/flush clear, stall holds, otherwise the
  // decode values arrive with side-effect controls forced low for a bubble.
  task automatic model_edge();
    if (rst || FlushE) begin
      foreach (exp_q[i]) exp_q[i] = '0;
    end else if (!StallE) begin
      exp_q[0]  = 32'(ValidD);
      exp_q[1]  = ValidD ? 32'(RegWriteD) : 32'd0;
      exp_q[2]  = 32'(ResultSrcD);
      exp_q[3]  = ValidD ? 32'(MemWriteD) : 32'd0;
      exp_q[4]  = ValidD ? 32'(JumpD)     : 32'd0;
      exp_q[5]  = ValidD ? 32'(BranchD)   : 32'd0;
      exp_q[6]  = 32'(ALUControlD);
      exp_q[7]  = 32'(ALUSrcD);
      exp_q[8]  = 32'(Funct3D);
      exp_q[9]  = RD1D;
      exp_q[10] = RD2D;
      exp_q[11] = ImmExtD;
      exp_q[12] = PCD;
      exp_q[13] = PCPlus4D;
      exp_q[14] = 32'(Rs1D);
      exp_q[15] = 32'(Rs2D);
      exp_q[16] = 32'(RdD);
    end
  endtask

  task automatic check_all();
    check("ValidE",      32'(ValidE),      exp_q[0]);
    check("RegWriteE",   32'(RegWriteE),   exp_q[1]);
    check("ResultSrcE",  32'(ResultSrcE),  exp_q[2]);
    check("MemWriteE",   32'(MemWriteE),   exp_q[3]);
    check("JumpE",       32'(JumpE),       exp_q[4]);
    check("BranchE",     32'(BranchE),     exp_q[5]);
    check("ALUControlE", 32'(ALUControlE), exp_q[6]);
    check("ALUSrcE",     32'(ALUSrcE),     exp_q[7]);
    check("Funct3E",     32'(Funct3E),     exp_q[8]);
    check("RD1E",        RD1E,             exp_q[9]);
    check("RD2E",        RD2E,             exp_q[10]);
    check("ImmExtE",     ImmExtE,          exp_q[11]);
    check("PCE",         PCE,              exp_q[12]);
    check("PCPlus4E",    PCPlus4E,         exp_q[13]);
    check("Rs1E",        32'(Rs1E),        exp_q[14]);
    check("Rs2E",        32'(Rs2E),        exp_q[15]);
    check("RdE",         32'(RdE),         exp_q[16]);
  endtask

  // One clock: inputs are already stable; outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_d();
    ValidD      = 1'($urandom);
    RegWriteD   = 1'($urandom);
    ResultSrcD  = 2'($urandom);
    MemWriteD   = 1'($urandom);
    JumpD       = 1'($urandom);
    BranchD     = 1'($urandom);
    ALUControlD = 3'($urandom);
    ALUSrcD     = 1'($urandom);
    Funct3D     = 3'($urandom);
    RD1D        = $urandom;
    RD2D        = $urandom;
    ImmExtD     = $urandom;
    PCD         = $urandom;
    PCPlus4D    = PCD + 32'd4;
    Rs1D        = 5'($urandom);
    Rs2D        = 5'($urandom);
    RdD         = 5'($urandom);
  endtask

  task automatic force_nonzero();
    ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1;
    BranchD = 1'b1; ALUSrcD = 1'b1; ResultSrcD = 2'b11; ALUControlD = 3'b111;
    Funct3D = 3'b101; RD1D |= 32'h1; RD2D |= 32'h1; ImmExtD |= 32'h1;
    PCD |= 32'h1; PCPlus4D |= 32'h1; Rs1D |= 5'h1; Rs2D |= 5'h1; RdD |= 5'h1;
  endtask

  logic [31:0] saved_rd1;
  logic [4:0]  saved_rd;

  initial begin
    foreach (exp_q[i]) exp_q[i] = '0;
    StallE = 1'b0; FlushE = 1'b0;

    // 1: reset for two cycles with non-zero inputs.
    rst = 1'b1;
    rand_d(); force_nonzero();
    step();
    check("rst_valid", 32'(ValidE), 32'd0);
    check("rst_rd1",   RD1E,        32'd0);
    rand_d(); force_nonzero();
    step();
    rst = 1'b0;

    // 2: normal load with 1-cycle latency.
    rand_d();
    ValidD = 1'b1; RegWriteD = 1'b1; ALUControlD = 3'b010;
    RD1D = 32'hDEADBEEF; RdD = 5'd7;
    step();
    check("load_valid", 32'(ValidE),      32'd1);
    check("load_rw",    32'(RegWriteE),   32'd1);
    check("load_alu",   32'(ALUControlE), 32'd2);
    check("load_rd1",   RD1E,             32'hDEADBEEF);
    check("load_rd",    32'(RdE),         32'd7);

    // 3: three stall cycles with changing inputs, then release.
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step();
      check("stall_rd1", RD1E,        32'hDEADBEEF);
      check("stall_rd",  32'(RdE),    32'd7);
    end
    StallE = 1'b0;
    rand_d();
    saved_rd1 = RD1D; saved_rd = RdD;
    step();
    check("unstall_rd1", RD1E,     saved_rd1);
    check("unstall_rd",  32'(RdE), 32'(saved_rd));

    // 4: flush overrides stall while E holds a valid store.
    rand_d(); ValidD = 1'b1; MemWriteD = 1'b1;
    step();
    check("store_mw", 32'(MemWriteE), 32'd1);
    StallE = 1'b1; FlushE = 1'b1;
    rand_d();
    step();
    check("flush_mw",    32'(MemWriteE), 32'd0);
    check("flush_valid", 32'(ValidE),    32'd0);
    check("flush_pc",    PCE,            32'd0);
    StallE = 1'b0; FlushE = 1'b0;

    // 5: bubble gating of side-effect controls.
    rand_d();
    ValidD = 1'b0; JumpD = 1'b1; BranchD = 1'b1; MemWriteD = 1'b1;
    RegWriteD = 1'b1; PCD = 32'h40;
    step();
    check("bubble_jump",   32'(JumpE),     32'd0);
    check("bubble_branch", 32'(BranchE),   32'd0);
    check("bubble_mw",     32'(MemWriteE), 32'd0);
    check("bubble_rw",     32'(RegWriteE), 32'd0);
    check("bubble_valid",  32'(ValidE),    32'd0);
    check("bubble_pc",     PCE,            32'h40);

    // 6: reset in the middle of a stall, then normal load.
    rand_d(); force_nonzero();
    step();
    StallE = 1'b1;
    rand_d();
    step();
    check("ms_hold_valid", 32'(ValidE), 32'd1);
    rst = 1'b1;
    step();
    check("ms_rst_valid", 32'(ValidE), 32'd0);
    check("ms_rst_rd1",   RD1E,        32'd0);
    rst = 1'b0; StallE = 1'b0;
    rand_d();
    saved_rd1 = RD1D;
    step();
    check("ms_reload_rd1", RD1E, saved_rd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_d();
      ValidD = ($urandom_range(3, 0) != 0);
      StallE = ($urandom_range(3, 0) == 0);
      FlushE = ($urandom_range(7, 0) == 0);
      rst    = ($urandom_range(49, 0) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
